// File: rtl/conv_engine_arbiter.sv
// Frame-granular round-robin arbiter that shares one 1-D convolution engine between two stream requesters.
// Define CONV_ARB_STATS_EN to add the per-requester completed-frame counters frames0/frames1.
`timescale 1ns/1ps
module conv_engine_arbiter #(
    parameter int T        = 16,
    parameter int X_COUNT  = 64,
    parameter int F_COUNT  = 33,
    parameter int OP_COUNT = X_COUNT - F_COUNT + 1,
    parameter int CNT_W    = $clog2(X_COUNT) + 1
) (
    input  logic                clk,
    input  logic                reset,

    input  logic signed [T-1:0] s0_data_x,
    input  logic                s0_valid_x,
    output logic                s0_ready_x,

    input  logic signed [T-1:0] s1_data_x,
    input  logic                s1_valid_x,
    output logic                s1_ready_x,

    output logic signed [T-1:0] e_data_x,
    output logic                e_valid_x,
    input  logic                e_ready_x,

    input  logic signed [T-1:0] e_data_y,
    input  logic                e_valid_y,
    output logic                e_ready_y,

    output logic signed [T-1:0] m0_data_y,
    output logic                m0_valid_y,
    input  logic                m0_ready_y,

    output logic signed [T-1:0] m1_data_y,
    output logic                m1_valid_y,
    input  logic                m1_ready_y,

    output logic                owner,
    output logic                busy
`ifdef CONV_ARB_STATS_EN
    ,
    output logic [15:0]         frames0,
    output logic [15:0]         frames1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rrNext_q, rrNext_d;
    logic [CNT_W-1:0] inCnt_q, inCnt_d;
    logic [CNT_W-1:0] outCnt_q, outCnt_d;
    logic             inFire;
    logic             outFire;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            rrNext_q <= 1'b0;
            inCnt_q  <= '0;
            outCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rrNext_q <= rrNext_d;
            inCnt_q  <= inCnt_d;
            outCnt_q <= outCnt_d;
        end
    end

    // Engine results arriving during LOAD see e_ready_y=0, so the engine holds them until DRAIN.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rrNext_d   = rrNext_q;
        inCnt_d    = inCnt_q;
        outCnt_d   = outCnt_q;
        inFire     = 1'b0;
        outFire    = 1'b0;
        e_data_x   = '0;
        e_valid_x  = 1'b0;
        s0_ready_x = 1'b0;
        s1_ready_x = 1'b0;
        e_ready_y  = 1'b0;
        m0_data_y  = '0;
        m0_valid_y = 1'b0;
        m1_data_y  = '0;
        m1_valid_y = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (s0_valid_x && s1_valid_x) begin
                    owner_d = rrNext_q;
                    state_d = LOAD;
                end else if (s0_valid_x) begin
                    owner_d = 1'b0;
                    state_d = LOAD;
                end else if (s1_valid_x) begin
                    owner_d = 1'b1;
                    state_d = LOAD;
                end
            end

            LOAD: begin
                e_data_x   = owner_q ? s1_data_x : s0_data_x;
                e_valid_x  = owner_q ? s1_valid_x : s0_valid_x;
                s0_ready_x = !owner_q && e_ready_x;
                s1_ready_x = owner_q && e_ready_x;
                inFire     = (owner_q ? s1_valid_x : s0_valid_x) && e_ready_x;
                if (inFire) begin
                    if (inCnt_q == CNT_W'(X_COUNT - 1)) begin
                        inCnt_d = '0;
                        state_d = DRAIN;
                    end else begin
                        inCnt_d = inCnt_q + 1'b1;
                    end
                end
            end

            DRAIN: begin
                m0_valid_y = !owner_q && e_valid_y;
                m1_valid_y = owner_q && e_valid_y;
                m0_data_y  = owner_q ? '0 : e_data_y;
                m1_data_y  = owner_q ? e_data_y : '0;
                e_ready_y  = owner_q ? m1_ready_y : m0_ready_y;
                outFire    = e_valid_y && (owner_q ? m1_ready_y : m0_ready_y);
                if (outFire) begin
                    if (outCnt_q == CNT_W'(OP_COUNT - 1)) begin
                        outCnt_d = '0;
                        state_d  = IDLE;
                        rrNext_d = !owner_q;
                    end else begin
                        outCnt_d = outCnt_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign owner = owner_q;
    assign busy  = (state_q != IDLE);

`ifdef CONV_ARB_STATS_EN
    logic [15:0] frames0_q, frames0_d;
    logic [15:0] frames1_q, frames1_d;
    logic        frameDone;

    assign frameDone = (state_q == DRAIN) && (state_d == IDLE);

    // Counters wrap naturally at 16 bits.
    always_comb begin
        frames0_d = frames0_q;
        frames1_d = frames1_q;
        if (frameDone) begin
            if (owner_q) begin
                frames1_d = frames1_q + 16'd1;
            end else begin
                frames0_d = frames0_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frames0_q <= '0;
            frames1_q <= '0;
        end else begin
            frames0_q <= frames0_d;
            frames1_q <= frames1_d;
        end
    end

    assign frames0 = frames0_q;
    assign frames1 = frames1_q;
`endif

endmodule

// File: tb/tb_conv_engine_arbiter.sv
// Directed testbench for conv_engine_arbiter; the bench plays both requesters, the engine and both consumers.
// Stats checks compile in when CONV_ARB_STATS_EN is defined.
`timescale 1ns/1ps
module tb_conv_engine_arbiter;

    localparam int T        = 16;
    localparam int X_COUNT  = 64;
    localparam int OP_COUNT = 32;

    logic                clk = 1'b0;
    logic                reset;
    logic signed [T-1:0] s0_data_x, s1_data_x, e_data_x, e_data_y, m0_data_y, m1_data_y;
    logic                s0_valid_x, s0_ready_x, s1_valid_x, s1_ready_x;
    logic                e_valid_x, e_ready_x, e_valid_y, e_ready_y;
    logic                m0_valid_y, m0_ready_y, m1_valid_y, m1_ready_y;
    logic                owner, busy;
`ifdef CONV_ARB_STATS_EN
    logic [15:0]         frames0, frames1;
`endif

    int errors = 0;
    int checks = 0;
    int expFrames0 = 0;
    int expFrames1 = 0;

    always #5 clk = ~clk;

    conv_engine_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .s0_data_x  (s0_data_x),
        .s0_valid_x (s0_valid_x),
        .s0_ready_x (s0_ready_x),
        .s1_data_x  (s1_data_x),
        .s1_valid_x (s1_valid_x),
        .s1_ready_x (s1_ready_x),
        .e_data_x   (e_data_x),
        .e_valid_x  (e_valid_x),
        .e_ready_x  (e_ready_x),
        .e_data_y   (e_data_y),
        .e_valid_y  (e_valid_y),
        .e_ready_y  (e_ready_y),
        .m0_data_y  (m0_data_y),
        .m0_valid_y (m0_valid_y),
        .m0_ready_y (m0_ready_y),
        .m1_data_y  (m1_data_y),
        .m1_valid_y (m1_valid_y),
        .m1_ready_y (m1_ready_y),
        .owner      (owner),
        .busy       (busy)
`ifdef CONV_ARB_STATS_EN
        ,
        .frames0    (frames0),
        .frames1    (frames1)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic v1,
                                 input logic signed [T-1:0] d0, input logic signed [T-1:0] d1,
                                 input logic erx, input logic evy, input logic signed [T-1:0] dy,
                                 input logic mr0, input logic mr1);
        s0_valid_x = v0;
        s1_valid_x = v1;
        s0_data_x  = d0;
        s1_data_x  = d1;
        e_ready_x  = erx;
        e_valid_y  = evy;
        e_data_y   = dy;
        m0_ready_y = mr0;
        m1_ready_y = mr1;
    endtask

    // One IDLE cycle: requests are presented but nothing may pass through yet.
    task automatic idleCycle(input logic r0, input logic r1, input string tag);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(r0, r1, 16'sd5, 16'sd6, 1'b1, 1'b1, 16'sd7, 1'b1, 1'b1);
        #1;
        checkOutput({tag, "_busy"},    32'(busy),       32'd0);
        checkOutput({tag, "_s0rdy"},   32'(s0_ready_x), 32'd0);
        checkOutput({tag, "_s1rdy"},   32'(s1_ready_x), 32'd0);
        checkOutput({tag, "_evx"},     32'(e_valid_x),  32'd0);
        checkOutput({tag, "_edx"},     32'(e_data_x),   32'd0);
        checkOutput({tag, "_erdy_y"},  32'(e_ready_y),  32'd0);
        checkOutput({tag, "_m0v"},     32'(m0_valid_y), 32'd0);
        checkOutput({tag, "_m1v"},     32'(m1_valid_y), 32'd0);
        checkOutput({tag, "_m0d"},     32'(m0_data_y),  32'd0);
        checkOutput({tag, "_m1d"},     32'(m1_data_y),  32'd0);
    endtask

    task automatic loadFrame(input int who, input int base, input int n, input bit bp, input logic otherReq);
        int sent = 0;
        int cyc = 0;
        logic erx;
        logic signed [T-1:0] dx;
        while (sent < n && cyc < 400) begin
            @(negedge clk);
            erx = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            dx  = T'(base + sent);
            if (who == 0)
                applyStimulus(1'b1, otherReq, dx, 16'sh1234, erx, bp, 16'sh0bad, 1'b1, 1'b1);
            else
                applyStimulus(otherReq, 1'b1, 16'sh1234, dx, erx, bp, 16'sh0bad, 1'b1, 1'b1);
            #1;
            checkOutput("load_busy",   32'(busy),      32'd1);
            checkOutput("load_owner",  32'(owner),     32'(who));
            checkOutput("load_evx",    32'(e_valid_x), 32'd1);
            checkOutput("load_edx",    32'(e_data_x),  32'(dx));
            checkOutput("load_own_rdy",   32'(who == 0 ? s0_ready_x : s1_ready_x), 32'(erx));
            checkOutput("load_other_rdy", 32'(who == 0 ? s1_ready_x : s0_ready_x), 32'd0);
            checkOutput("load_erdy_y", 32'(e_ready_y),  32'd0);
            checkOutput("load_m0v",    32'(m0_valid_y), 32'd0);
            checkOutput("load_m1v",    32'(m1_valid_y), 32'd0);
            if (erx) sent++;
            cyc++;
        end
        checkOutput("load_count", 32'(sent), 32'(n));
    endtask

    task automatic drainFrame(input int who, input int base, input bit bp, input logic otherReq);
        int got = 0;
        int cyc = 0;
        logic evy, mr;
        logic signed [T-1:0] dy;
        while (got < OP_COUNT && cyc < 400) begin
            @(negedge clk);
            evy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            mr  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            dy  = T'(base - 3 * got);
            if (who == 0)
                applyStimulus(1'b1, otherReq, 16'sh0101, 16'sh0202, 1'b1, evy, dy, mr, 1'b1);
            else
                applyStimulus(otherReq, 1'b1, 16'sh0101, 16'sh0202, 1'b1, evy, dy, 1'b1, mr);
            #1;
            checkOutput("drain_busy",  32'(busy),       32'd1);
            checkOutput("drain_owner", 32'(owner),      32'(who));
            checkOutput("drain_s0rdy", 32'(s0_ready_x), 32'd0);
            checkOutput("drain_s1rdy", 32'(s1_ready_x), 32'd0);
            checkOutput("drain_evx",   32'(e_valid_x),  32'd0);
            checkOutput("drain_erdy_y", 32'(e_ready_y), 32'(mr));
            checkOutput("drain_own_v", 32'(who == 0 ? m0_valid_y : m1_valid_y), 32'(evy));
            checkOutput("drain_own_d", 32'(who == 0 ? m0_data_y : m1_data_y),   32'(dy));
            checkOutput("drain_oth_v", 32'(who == 0 ? m1_valid_y : m0_valid_y), 32'd0);
            checkOutput("drain_oth_d", 32'(who == 0 ? m1_data_y : m0_data_y),   32'd0);
            if (evy && mr) got++;
            cyc++;
        end
        checkOutput("drain_count", 32'(got), 32'(OP_COUNT));
        if (who == 0) expFrames0++;
        else          expFrames1++;
    endtask

    task automatic runFrame(input int who, input int base);
        idleCycle(who == 0, who == 1, "rf_grant");
        loadFrame(who, base, X_COUNT, 1'b0, 1'b0);
        drainFrame(who, base + 1000, 1'b0, 1'b0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 16'sd9, 16'sd10, 1'b1, 1'b1, 16'sd11, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_busy",  32'(busy),       32'd0);
        checkOutput("rst_owner", 32'(owner),      32'd0);
        checkOutput("rst_s0rdy", 32'(s0_ready_x), 32'd0);
        checkOutput("rst_s1rdy", 32'(s1_ready_x), 32'd0);
        checkOutput("rst_evx",   32'(e_valid_x),  32'd0);
        checkOutput("rst_edx",   32'(e_data_x),   32'd0);
        checkOutput("rst_erdy_y", 32'(e_ready_y), 32'd0);
        checkOutput("rst_m0v",   32'(m0_valid_y), 32'd0);
        checkOutput("rst_m1v",   32'(m1_valid_y), 32'd0);

        // Single requester s0 with samples 1..64.
        idleCycle(1'b0, 1'b0, "t1_pre");
        idleCycle(1'b1, 1'b0, "t1_grant");
        loadFrame(0, 1, X_COUNT, 1'b0, 1'b0);
        drainFrame(0, -20, 1'b0, 1'b0);
        idleCycle(1'b0, 1'b0, "t1_idle");

        // Simultaneous requests straight out of reset: s0 first, then s1 after one IDLE cycle.
        @(negedge clk);
        reset = 1'b1;
        expFrames0 = 0;
        expFrames1 = 0;
        idleCycle(1'b1, 1'b1, "t2_grant");
        loadFrame(0, 100, X_COUNT, 1'b0, 1'b1);
        drainFrame(0, 300, 1'b0, 1'b1);
        idleCycle(1'b1, 1'b1, "t2_gap");
        loadFrame(1, 200, X_COUNT, 1'b0, 1'b1);
        drainFrame(1, -300, 1'b0, 1'b1);

        // Contention after serving s1 goes back to s0.
        idleCycle(1'b1, 1'b1, "t3_grant");
        loadFrame(0, 400, X_COUNT, 1'b0, 1'b1);
        drainFrame(0, 600, 1'b0, 1'b1);
        idleCycle(1'b0, 1'b0, "t3_idle");

        // Random backpressure on both sides with early engine results during LOAD.
        idleCycle(1'b1, 1'b0, "t4_grant");
        loadFrame(0, 500, X_COUNT, 1'b1, 1'b0);
        drainFrame(0, 1000, 1'b1, 1'b0);
        idleCycle(1'b0, 1'b0, "t4_idle");

        // Reset after 20 of 64 samples, then a fresh frame from s1.
        idleCycle(1'b0, 1'b1, "t5_grant");
        loadFrame(1, 700, 20, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        expFrames0 = 0;
        expFrames1 = 0;
        idleCycle(1'b0, 1'b0, "t5_rst");
        checkOutput("t5_owner", 32'(owner), 32'd0);
        runFrame(1, 800);
        idleCycle(1'b0, 1'b0, "t5_idle");

`ifdef CONV_ARB_STATS_EN
        runFrame(0, 10);
        runFrame(0, 20);
        runFrame(0, 30);
        runFrame(1, 40);
        idleCycle(1'b0, 1'b0, "st_idle");
        checkOutput("st_frames0", 32'(frames0), 32'd3);
        checkOutput("st_frames1", 32'(frames1), 32'd2);
        checkOutput("st_exp0",    32'(frames0), 32'(expFrames0));
        checkOutput("st_exp1",    32'(frames1), 32'(expFrames1));
        @(negedge clk);
        force dut.frames0_q = 16'hFFFF;
        @(negedge clk);
        release dut.frames0_q;
        #1;
        checkOutput("st_forced", 32'(frames0), 32'h0000FFFF);
        runFrame(0, 50);
        idleCycle(1'b0, 1'b0, "st_wrap_idle");
        checkOutput("st_wrap", 32'(frames0), 32'd0);
        checkOutput("st_wrap_f1", 32'(frames1), 32'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_engine_arbiter.md
Name: conv_engine_arbiter

Overview:
- Shares one 1-D convolution engine (X_COUNT-sample input frame, OP_COUNT outputs per frame) between two stream requesters.
- Grants the engine a whole frame at a time: passes the owner's X_COUNT input samples in, then returns the engine's OP_COUNT results to the same owner.
- Sits between two upstream producers/downstream consumers and the conv engine's valid/ready ports. Round-robin arbitration at frame granularity.

Parameters:
- T, 16, sample/result width (signed)
- X_COUNT, 64, input samples per frame
- F_COUNT, 33, filter taps (used only to derive OP_COUNT)
- OP_COUNT, X_COUNT-F_COUNT+1 (32), results per frame
- CNT_W, $clog2(X_COUNT)+1, width of internal counters

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- s0_data_x  in  T  requester 0 input sample
- s0_valid_x  in  1  requester 0 sample valid
- s0_ready_x  out  1  requester 0 sample accepted
- s1_data_x  in  T  requester 1 input sample
- s1_valid_x  in  1  requester 1 sample valid
- s1_ready_x  out  1  requester 1 sample accepted
- e_data_x  out  T  sample to engine
- e_valid_x  out  1  sample valid to engine
- e_ready_x  in  1  engine ready for sample
- e_data_y  in  T  engine result
- e_valid_y  in  1  engine result valid
- e_ready_y  out  1  result accepted from engine
- m0_data_y  out  T  result to consumer 0
- m0_valid_y  out  1  result valid to consumer 0
- m0_ready_y  in  1  consumer 0 ready
- m1_data_y  out  T  result to consumer 1
- m1_valid_y  out  1  result valid to consumer 1
- m1_ready_y  in  1  consumer 1 ready
- owner  out  1  current/last granted requester
- busy  out  1  high in LOAD or DRAIN

Behaviour:
- Reset: state IDLE, owner=0, rr_next=0 (requester 0 preferred), in_cnt=0, out_cnt=0. In IDLE all readies/valids are 0 and data outputs are 0; busy=0.
- Reset mid-frame abandons the frame. The engine shares the same reset, so no partial state survives.
- IDLE: if exactly one sN_valid_x=1, grant N. If both, grant rr_next. Grant registers owner and moves to LOAD on the next edge (1-cycle arbitration latency). No samples are accepted in IDLE.
- LOAD: combinational pass-through. e_data_x=s[owner]_data_x, e_valid_x=s[owner]_valid_x, s[owner]_ready_x=e_ready_x; non-owner ready=0.
  - in_cnt increments on each e_valid_x&e_ready_x.
  - Handshake with in_cnt==X_COUNT-1 -> DRAIN, in_cnt<=0.
  - e_ready_y=0 in LOAD; early engine results are held, never dropped.
- DRAIN: m[owner]_valid_y=e_valid_y, m[owner]_data_y=e_data_y, e_ready_y=m[owner]_ready_y; non-owner valid=0, data=0. All s*_ready_x=0.
  - out_cnt increments on each e_valid_y&e_ready_y.
  - Handshake with out_cnt==OP_COUNT-1 -> IDLE, out_cnt<=0, rr_next<=~owner.
- Round-robin: the requester just served has the lower priority on the next contention. A lone requester may be granted back-to-back.
- Data is passed unmodified; no arithmetic or saturation in this block. Results stay signed T bits.
- Non-owner valid held high for any length of time is not an error; it waits with ready=0.
- Back-to-back frames: IDLE lasts exactly one cycle between a DRAIN end and the next LOAD when a request is pending.

Optional Feature:
- CONV_ARB_STATS_EN defined: adds outputs frames0 and frames1 (16 bits each, reset 0). frameN increments at the DRAIN->IDLE transition when owner==N and wraps at 65535->0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Single requester: s0 streams 64 samples (values 1..64), e_ready_x=1. Required: grant after 1 cycle, s1_ready_x=0 throughout, exactly 64 handshakes to the engine. Then 32 engine results appear only on m0, busy falls after the 32nd.
- Simultaneous requests right after reset: both valid at cycle 0. Required: requester 0 is served first, then requester 1 with one IDLE cycle between, owner toggles 0->1.
- Contention after serving 1: both request again. Required: requester 0 is granted, confirming rr_next rotation.
- Backpressure: random e_ready_x and m0_ready_y at 50%, e_valid_y asserted during LOAD. Required: no sample lost or duplicated, e_ready_y=0 until DRAIN, result order preserved, counts 64/32.
- Reset asserted after 20 of 64 samples. Required: next cycle is IDLE, all readies/valids are 0, owner=0, and a fresh frame from s1 completes normally.
- With CONV_ARB_STATS_EN: 3 frames from s0 and 2 from s1. Required: frames0=3, frames1=2. Forcing frames0=65535 then one frame gives 0.
